mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DWIDTH, from InstructionStruct, data width; AWIDTH, from InstructionStruct, address width; none local.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-005 i_addr  input  AWIDTH  fetch address, stable while i_req.
REQ-006 i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata  output  DWIDTH  fetch data, valid while i_ack.
REQ-008 d_req  input  1  data-port request, held until d_ack.
REQ-009 d_we  input  1  1 = write, 0 = read, stable while d_req.
REQ-010 d_addr  input  AWIDTH  data address, stable while d_req.
REQ-011 d_wdata  input  DWIDTH  write data, stable while d_req.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  DWIDTH  read data, valid while d_ack.
REQ-014 mem_data  inout  DWIDTH  shared tri-state bus to the RAM.
REQ-015 mem_addr  output  AWIDTH  RAM address.
REQ-016 mem_rdEn  output  1  RAM read enable; the RAM drives mem_data while high.
REQ-017 mem_wrEn  output  1  RAM write enable; the RAM writes on posedge when wrEn=1 and rdEn=0.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, ACK, and all outputs SHALL be registered or decoded from state/grant only.
REQ-020 In IDLE, the arbiter SHALL sample i_req and d_req and latch a grant (I or D) plus a latched address, op and write data.
REQ-021 If exactly one request is present, that request SHALL be granted.
REQ-022 If both requests are present, the port not granted last SHALL win (round-robin).
REQ-023 The last-grant pointer SHALL update only on grant.
REQ-024 If no request is present, the FSM SHALL stay in IDLE.
REQ-025 A grant to I, or to D with d_we=0, SHALL go to RD; a grant to D with d_we=1 SHALL go to WR.
REQ-026 RD: mem_rdEn=1, mem_wrEn=0, mem_addr=latched address, mem_data released (Z).
REQ-027 RD: mem_data SHALL be captured at the posedge ending RD, and the FSM SHALL go to ACK.
REQ-028 WR: mem_rdEn=0, mem_wrEn=1, mem_addr=latched address, mem_data driven with latched wdata.
REQ-029 WR: the FSM SHALL go to ACK after one cycle.
REQ-030 The arbiter SHALL drive mem_data only in WR, and mem_rdEn and the arbiter's bus drive SHALL never be active in the same cycle.
REQ-031 ACK: the granted port's ack=1 for exactly one cycle, and its rdata SHALL hold the captured word (reads) or be unchanged (writes).
REQ-032 After ACK the FSM SHALL return to IDLE unconditionally.
REQ-033 Latency SHALL be req seen in IDLE to ack asserted = 2 cycles; the access period SHALL be 3 cycles per transaction.
REQ-034 Requesters SHALL drop req at the edge ending their ack cycle, so a req still high in IDLE is a new request.
REQ-035 A request arriving in RD, WR or ACK SHALL wait and be arbitrated at the next IDLE.
REQ-036 i_rdata/d_rdata SHALL hold their last value between acks.
REQ-037 mem_addr SHALL be 0 in IDLE and ACK.

Reset
REQ-038 reset=0 SHALL asynchronously force IDLE, with busy, i_ack, d_ack, mem_rdEn, mem_wrEn, mem_addr, i_rdata and d_rdata = 0.
REQ-039 reset=0 SHALL release mem_data to Z and set the last-grant pointer to D, so I wins the first tie.
REQ-040 Reset asserted mid-RD or mid-WR SHALL abort the transaction with no ack; the requester reissues.
REQ-041 On reset release, the FSM SHALL resume sampling in the first IDLE cycle.

Verification
REQ-042 Fetch only: i_req=1, i_addr=5, RAM word 5=0x1234 -> mem_rdEn high for 1 cycle, i_ack 2 cycles after the request, i_rdata=0x1234.
REQ-043 Data write then read: d_we=1, d_addr=3, d_wdata=0xBEEF, then a read of 3 -> write: mem_wrEn=1 with mem_rdEn=0 and d_ack; read: d_rdata=0xBEEF.
REQ-044 Tie after reset: i_req and d_req held continuously -> grants I, D, I, D, with acks every 3 cycles.
REQ-045 Contention check: random mixed traffic -> mem_data never driven by both sides, with no X on the bus while mem_rdEn=1.
REQ-046 Reset mid-WR: assert reset during WR -> no d_ack, outputs 0, bus Z, RAM word unchanged unless the write edge has already occurred.
REQ-047 Late request: d_req rises during I's RD -> D granted in the IDLE following I's ACK.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake and RAM control signals of the instruction/data memory arbiter.
// The shared tri-state data bus stays a plain inout port on the arbiter.
interface mem_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
);
    logic              i_req;
    logic [AWIDTH-1:0] i_addr;
    logic              i_ack;
    logic [DWIDTH-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_ack;
    logic [DWIDTH-1:0] d_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rdEn;
    logic              mem_wrEn;
    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_rdEn, mem_wrEn, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_rdEn, mem_wrEn, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an instruction-fetch port and a
// data port; every access is IDLE -> RD/WR -> ACK, three cycles per transaction.
module mem_arbiter #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              grant_d_r;
    logic              grant_d_s;
    logic              last_d_r;
    logic              last_d_s;
    logic [AWIDTH-1:0] addr_s;
    logic [AWIDTH-1:0] mem_addr_r;
    logic [DWIDTH-1:0] wdata_r;
    logic [DWIDTH-1:0] wdata_s;
    logic [DWIDTH-1:0] i_rdata_r;
    logic [DWIDTH-1:0] d_rdata_r;
    logic              rd_en_r;
    logic              wr_en_r;
    logic              busy_r;
    logic              i_ack_r;
    logic              d_ack_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, grant selection and latched transaction fields
    always_comb begin
        next_state_s = state_r;
        grant_d_s    = grant_d_r;
        last_d_s     = last_d_r;
        addr_s       = {AWIDTH{1'b0}};
        wdata_s      = wdata_r;
        case (state_r)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the port that did not win last time gets the RAM.
                    grant_d_s    = bus.d_req && (!bus.i_req || !last_d_r);
                    last_d_s     = grant_d_s;
                    addr_s       = grant_d_s ? bus.d_addr : bus.i_addr;
                    next_state_s = (grant_d_s && bus.d_we) ? WR : RD;
                    if (grant_d_s) begin
                        wdata_s = bus.d_wdata;
                    end else begin
                        wdata_s = wdata_r;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD:      next_state_s = ACK;
            WR:      next_state_s = ACK;
            ACK:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Registered datapath and outputs, all derived from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_d_r  <= 1'b0;
            last_d_r   <= 1'b1;
            wdata_r    <= {DWIDTH{1'b0}};
            mem_addr_r <= {AWIDTH{1'b0}};
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            i_ack_r    <= 1'b0;
            d_ack_r    <= 1'b0;
            i_rdata_r  <= {DWIDTH{1'b0}};
            d_rdata_r  <= {DWIDTH{1'b0}};
        end else begin
            grant_d_r  <= grant_d_s;
            last_d_r   <= last_d_s;
            wdata_r    <= wdata_s;
            mem_addr_r <= addr_s;
            rd_en_r    <= (next_state_s == RD);
            wr_en_r    <= (next_state_s == WR);
            busy_r     <= (next_state_s != IDLE);
            i_ack_r    <= (next_state_s == ACK) && !grant_d_s;
            d_ack_r    <= (next_state_s == ACK) && grant_d_s;
            // The RAM word is taken on the edge that closes the read cycle.
            if (state_r == RD) begin
                if (grant_d_r) begin
                    d_rdata_r <= mem_data;
                end else begin
                    i_rdata_r <= mem_data;
                end
            end
        end
    end

    assign mem_data     = (state_r == WR) ? wdata_r : {DWIDTH{1'bz}};
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_rdEn = rd_en_r;
    assign bus.mem_wrEn = wr_en_r;
    assign bus.busy     = busy_r;
    assign bus.i_ack    = i_ack_r;
    assign bus.d_ack    = d_ack_r;
    assign bus.i_rdata  = i_rdata_r;
    assign bus.d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM on the tri-state bus, a vector table of single
// transactions, hand-written tie/late-request/reset sequences and random traffic.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    logic ram_load;
    wire [DW-1:0] mem_data;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .mem_data (mem_data)
    );

    function automatic logic [15:0] init_word(input int k);
        logic [7:0] b;
        b = k[7:0];
        if (k == 5) return 16'h1234;
        return {b, ~b};
    endfunction

    // RAM model: drives the bus while read-enabled, writes on wrEn && !rdEn
    logic [DW-1:0] ram [256];
    assign mem_data = bus.mem_rdEn ? ram[bus.mem_addr] : {DW{1'bz}};
    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
        end else if (bus.mem_wrEn && !bus.mem_rdEn) begin
            ram[bus.mem_addr] <= mem_data;
        end
    end

    typedef struct {
        logic        port_d;
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        port_d;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[12];
    logic [15:0] model[256];
    logic [15:0] last_i_m;
    logic [15:0] last_d_m;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: pops the expected completion on every ack and watches the bus
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_rdEn && bus.mem_wrEn) begin
                n_err++;
                $display("FAIL bus_contention: rdEn=1 wrEn=1, expected at most one (cycle %0d)", cyc);
            end
            if (bus.mem_rdEn && $isunknown(mem_data)) begin
                n_err++;
                $display("FAIL bus_x: mem_data=%h during read, expected known (cycle %0d)", mem_data, cyc);
            end
            if (bus.i_ack || bus.d_ack) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, expected none (cycle %0d)",
                             bus.i_ack, bus.d_ack, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port", 32'({bus.i_ack, bus.d_ack}), mon_e.port_d ? 32'd1 : 32'd2);
                    if (mon_e.port_d) begin
                        if (mon_e.is_read) begin
                            check("d_rdata", 32'(bus.d_rdata), 32'(mon_e.data));
                            last_d_m = mon_e.data;
                        end else begin
                            check("d_rdata_hold", 32'(bus.d_rdata), 32'(last_d_m));
                        end
                    end else begin
                        check("i_rdata", 32'(bus.i_rdata), 32'(mon_e.data));
                        last_i_m = mon_e.data;
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = 8'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'd0;
        bus.d_wdata = 16'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_ack",     32'({bus.i_ack, bus.d_ack}), 32'd0);
        check("rst_en",      32'({bus.mem_rdEn, bus.mem_wrEn}), 32'd0);
        check("rst_addr",    32'(bus.mem_addr), 32'd0);
        check("rst_i_rdata", 32'(bus.i_rdata), 32'd0);
        check("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
        last_i_m = 16'd0;
        last_d_m = 16'd0;
        reset = 1'b1;
    endtask

    task automatic do_txn(input logic port_d, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata);
        sb.push_back('{port_d, !we, rdata});
        if (we) model[addr] = wdata;
        @(posedge clk); #1;
        if (port_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        @(posedge clk); #1;
        check("phase_en",   32'({bus.mem_rdEn, bus.mem_wrEn}), we ? 32'd1 : 32'd2);
        check("phase_addr", 32'(bus.mem_addr), 32'(addr));
        check("phase_busy", 32'(bus.busy), 32'd1);
        if (we) check("wr_bus", 32'(mem_data), 32'(wdata));
        @(posedge clk); #1;
        check("ack_latency", 32'(port_d ? bus.d_ack : bus.i_ack), 32'd1);
        check("ack_addr",    32'(bus.mem_addr), 32'd0);
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("ack_pulse", 32'({bus.i_ack, bus.d_ack}), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_ack(output int c, output logic dp);
        c  = -1;
        dp = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (bus.i_ack || bus.d_ack) begin
                c  = cyc;
                dp = bus.d_ack;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL ack_timeout: no ack within 8 cycles, expected one (cycle %0d)", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          prev;
        logic        dp;
        logic        pd;
        logic        we;
        logic [7:0]  a;
        logic [15:0] w;

        vecs[0]  = '{1'b0, 1'b0, 8'd5,   16'd0,     16'h1234};
        vecs[1]  = '{1'b1, 1'b1, 8'd3,   16'hBEEF,  16'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'd3,   16'd0,     16'hBEEF};
        vecs[3]  = '{1'b0, 1'b0, 8'd3,   16'd0,     16'hBEEF};
        vecs[4]  = '{1'b1, 1'b1, 8'd10,  16'hA5A5,  16'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'd10,  16'd0,     16'hA5A5};
        vecs[6]  = '{1'b1, 1'b0, 8'd5,   16'd0,     16'h1234};
        vecs[7]  = '{1'b0, 1'b0, 8'd255, 16'd0,     16'hFF00};
        vecs[8]  = '{1'b1, 1'b1, 8'd0,   16'hFFFF,  16'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'd0,   16'd0,     16'hFFFF};
        vecs[10] = '{1'b0, 1'b0, 8'd0,   16'd0,     16'hFFFF};
        vecs[11] = '{1'b1, 1'b0, 8'd20,  16'd0,     16'h14EB};

        for (int k = 0; k < 256; k++) model[k] = init_word(k);
        last_i_m = 16'd0;
        last_d_m = 16'd0;
        reset    = 1'b0;
        ram_load = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        ram_load = 1'b0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].port_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
        end

        // Both ports requesting continuously straight after reset: I first, then alternate
        do_reset();
        sb.push_back('{1'b0, 1'b1, 16'h1234});
        sb.push_back('{1'b1, 1'b1, 16'hBEEF});
        sb.push_back('{1'b0, 1'b1, 16'h1234});
        sb.push_back('{1'b1, 1'b1, 16'hBEEF});
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 8'd5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd3;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(c, dp);
            check("tie_grant", 32'(dp), 32'(k % 2));
            if (k > 0) check("tie_spacing", 32'(c - prev), 32'd3);
            prev = c;
        end
        @(posedge clk); #1;
        drive_idle();

        // Data request rising while the fetch is in its read cycle
        sb.push_back('{1'b0, 1'b1, 16'h1234});
        sb.push_back('{1'b1, 1'b1, 16'hA5A5});
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 8'd5;
        @(posedge clk); #1;
        check("late_i_rd", 32'(bus.mem_rdEn), 32'd1);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd10;
        @(posedge clk); #1;
        check("late_i_ack", 32'({bus.i_ack, bus.d_ack}), 32'd2);
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        check("late_idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("late_d_rd", 32'({bus.mem_rdEn, bus.mem_addr}), 32'({1'b1, 8'd10}));
        @(posedge clk); #1;
        check("late_d_ack", 32'({bus.i_ack, bus.d_ack}), 32'd1);
        @(posedge clk); #1;
        drive_idle();

        // Reset in the middle of a write cycle, before the write edge
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd20; bus.d_wdata = 16'h1111;
        @(posedge clk); #1;
        check("mwr_wren", 32'({bus.mem_rdEn, bus.mem_wrEn}), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mwr_rst_out", 32'({bus.busy, bus.i_ack, bus.d_ack, bus.mem_rdEn, bus.mem_wrEn, bus.mem_addr}), 32'd0);
        check("mwr_rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 32'd0);
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        last_i_m = 16'd0;
        last_d_m = 16'd0;
        reset = 1'b1;
        check("mwr_ram", 32'(ram[20]), 32'h14EB);
        @(posedge clk); #1;
        check("mwr_idle", 32'(bus.busy), 32'd0);
        do_txn(1'b1, 1'b1, 8'd20, 16'h1111, 16'd0);
        do_txn(1'b1, 1'b0, 8'd20, 16'd0, 16'h1111);

        for (int r = 0; r < 24; r++) begin
            pd = 1'($urandom_range(0, 1));
            we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = 8'($urandom_range(0, 15));
            w  = 16'($urandom_range(0, 65535));
            do_txn(pd, we, a, w, model[a]);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
